// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and constants for the loader; IMEM_LOADER_CHECKSUM_EN adds S_CSUM
package imem_loader_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W_DEFAULT  = 16;
    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: little-endian 8->32 assembly register with a wrapping byte counter
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [23:0] asm_q, asm_d;
    logic [1:0]  cnt_q, cnt_d;
    // new bytes enter at the top so byte 0 ends up in bits [7:0] when the word completes
    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        if (clr) begin
            asm_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            asm_d = {in_byte, asm_q[23:8]};
            cnt_d = cnt_q + 2'd1;
        end
    end
    assign word_valid = in_valid && !clr && cnt_q == 2'(BYTES_PER_WORD - 1);
    assign word       = {in_byte, asm_q};
    // assembly state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_q <= '0;
            cnt_q <= '0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream writer for the instruction SRAM; IMEM_LOADER_CHECKSUM_EN enables a trailing XOR checksum byte
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = LEN_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       din,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);
    localparam int IDX_W = $clog2(DEPTH + 1);
    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  len_q, len_d, len_in;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       din_q, din_d;
    logic              done_q, done_d, err_q, err_d, core_rst_n_q, core_rst_n_d;
    logic              accept, pk_valid, last_word;
    logic [31:0]       pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    assign in_ready  = rst_n && state_q != S_DONE && state_q != S_ERR;
    assign accept    = in_valid && in_ready;
    assign len_in    = LEN_W'({in_data, len_lo_q});
    assign last_word = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;
    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state_q != S_DATA),
        .in_valid   (accept),
        .in_byte    (in_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );
    // header parsing, word sequencing and re-arm
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        idx_d    = idx_q;
        case (state_q)
            S_LEN0: if (accept) begin
                len_lo_d = in_data;
                state_d  = S_LEN1;
            end
            S_LEN1: if (accept) begin
                len_d   = len_in;
                idx_d   = '0;
                state_d = (len_in == '0 || int'(len_in) > DEPTH) ? S_ERR : S_DATA;
            end
            S_DATA: if (pk_valid) begin
                idx_d = idx_q + IDX_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (last_word) state_d = S_CSUM;
`else
                if (last_word) state_d = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
`endif
            S_DONE, S_ERR: if (start) begin
                state_d = S_LEN0;
                idx_d   = '0;
            end
            default: state_d = S_LEN0;
        endcase
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    // running XOR of payload bytes, held for the checksum compare and zero otherwise
    always_comb begin
        csum_d = (state_q == S_DATA) ? (accept ? csum_q ^ in_data : csum_q) : (state_q == S_CSUM ? csum_q : 8'h00);
    end
`endif
    // write port and status flags; done/err trail the state by one cycle so the last write lands first
    always_comb begin
        wr_en_d      = pk_valid;
        wr_addr_d    = pk_valid ? ADDR_W'(idx_q) : wr_addr_q;
        din_d        = pk_valid ? pk_word : din_q;
        done_d       = state_q == S_DONE && !start;
        err_d        = state_q == S_ERR && !start;
        core_rst_n_d = done_d;
    end
    // state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_LEN0;
            len_lo_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            din_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            din_q        <= din_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_rst_n_q <= core_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign din        = din_q;
    assign done       = done_q;
    assign err        = err_q;
    assign core_rst_n = core_rst_n_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads checked against a stream-level model
module tb_imem_loader;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 32;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              start = 1'b0;
    logic              in_ready, wr_en, core_rst_n, done, err;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       din;
    int                vectors = 0;
    int                miscompares = 0;
    int                cyc = 0;
    int                last_wr_cyc = 0;
    int                done_rise_cyc = 0;
    logic              done_prev = 1'b0;
    logic [31:0]       wa_q[$];
    logic [31:0]       wd_q[$];
    logic [31:0]       words[$];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .start      (start),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .din        (din),
        .core_rst_n (core_rst_n),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // log every write strobe and the cycle done rises
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(din);
            last_wr_cyc = cyc;
        end
        if (done && !done_prev) done_rise_cyc = cyc;
        done_prev = done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1 chk("in_ready_stream", in_ready, 1);
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // mid: 0 none, 1 idle stall inside word 0, 2 same stall with a start pulse
    task automatic run_load(input int n, input int max_gap, input bit bad_csum, input int mid);
        int   base;
        int   exp_n;
        int   got_n;
        bit   len_ok;
        bit   ok;
        logic [7:0] b;
        logic [7:0] x;
        base   = wa_q.size();
        len_ok = n >= 1 && n <= DEPTH;
        ok     = len_ok && !bad_csum;
        x      = 8'h00;
        send_byte(n[7:0], max_gap);
        send_byte(n[15:8], max_gap);
        if (len_ok) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (mid != 0 && i == 0 && k == 2) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                        start    = (mid == 2);
                        @(negedge clk);
                        start = 1'b0;
                        repeat (4) @(negedge clk);
                    end
                    b = words[i][8*k +: 8];
                    x = x ^ b;
                    send_byte(b, max_gap);
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(bad_csum ? ~x : x, max_gap);
`endif
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        exp_n = len_ok ? n : 0;
        got_n = wa_q.size() - base;
        chk("wr_count", got_n, exp_n);
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            chk("wr_addr", wa_q[base+i], i);
            chk("wr_data", wd_q[base+i], words[i]);
        end
        chk("done", done, ok);
        chk("err", err, !ok);
        chk("core_rst_n", core_rst_n, ok);
        chk("in_ready_idle", in_ready, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (ok) chk("done_latency", done_rise_cyc - last_wr_cyc, 1);
`endif
    endtask

    task automatic rearm();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("rearm_core_rst_n", core_rst_n, 0);
        chk("rearm_done", done, 0);
        chk("rearm_err", err, 0);
        chk("rearm_in_ready", in_ready, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_din", din, 0);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        words.delete();
        words.push_back(32'h0010C233);
        words.push_back(32'h002141B3);
        run_load(2, 0, 1'b0, 0);
        rearm();
        run_load(2, 0, 1'b0, 1);
        rearm();

        run_load(0, 0, 1'b0, 0);
        rearm();
        run_load(33, 0, 1'b0, 0);
        rearm();
        run_load(256, 1, 1'b0, 0);
        rearm();
        run_load(16'hFFFF, 0, 1'b0, 0);
        rearm();

        fill_random(1);
        run_load(1, 2, 1'b0, 0);
        rearm();
        fill_random(DEPTH);
        run_load(DEPTH, 1, 1'b0, 0);
        rearm();
        for (int t = 0; t < 4; t++) begin
            fill_random(int'($urandom_range(DEPTH, 1)));
            run_load(words.size(), 3, 1'b0, 0);
            rearm();
        end

        fill_random(2);
        run_load(2, 0, 1'b0, 2);
        rearm();

        fill_random(2);
        base = wa_q.size();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(words[i / 4][8*(i % 4) +: 8], 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        #1 chk_reset_outputs();
        chk("midrst_writes", wa_q.size() - base, 1);
        rst_n = 1'b1;
        fill_random(1);
        run_load(1, 0, 1'b0, 0);
        rearm();

`ifdef IMEM_LOADER_CHECKSUM_EN
        words.delete();
        words.push_back(32'h04030201);
        run_load(1, 0, 1'b0, 0);
        rearm();
        run_load(1, 0, 1'b1, 0);
        rearm();
        fill_random(3);
        run_load(3, 2, 1'b1, 0);
        rearm();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
